// File: rtl/uu_wb_arbiter_pkg.sv
// rtl/uu_wb_arbiter_pkg.sv - shared types and defaults for the writeback arbiter
// Contents: default parameter values, unit-index type, registered slot payload.
package uu_wb_arbiter_pkg;

   localparam int NUM_UNITS_DEF = 9;
   localparam int RD_W_DEF      = 5;
   localparam int ID_W_DEF      = 4;

   typedef logic [ID_W_DEF-1:0] unit_idx_t;

   // Slot fields are sized to the defaults; RD_W and ID_W must not exceed them.
   typedef struct packed {
      logic [RD_W_DEF-1:0] rd;
      logic                fp;
      unit_idx_t           unit;
   } wb_slot_t;

endpackage

// File: rtl/uu_wb_arbiter_rr_priority_picker.sv
// rtl/uu_wb_arbiter_rr_priority_picker.sv - round-robin first-set picker
// Ports: req (request vector), ptr (search start) -> gnt (one-hot),
//        gnt_idx (index of gnt), gnt_valid (any request present).
module rr_priority_picker
   import uu_wb_arbiter_pkg::*;
#(
   parameter int N  = NUM_UNITS_DEF,
   parameter int IW = ID_W_DEF
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_valid
);

   localparam int SW = IW + 1;

   logic [SW-1:0] pos;
   logic [IW-1:0] idx;

   // Walk N positions starting at ptr; the extra bit lets ptr+k exceed N-1
   // before a single subtraction folds it back into range.
   always_comb begin
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      pos       = '0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         pos = {1'b0, ptr} + SW'(k);
         if (pos >= SW'(N)) begin
            pos = pos - SW'(N);
         end
         idx = pos[IW-1:0];
         if (!gnt_valid && req[idx]) begin
            gnt_valid = 1'b1;
            gnt[idx]  = 1'b1;
            gnt_idx   = idx;
         end
      end
   end

endmodule

// File: rtl/uu_wb_arbiter.sv
// rtl/uu_wb_arbiter.sv - round-robin arbiter for a shared registered writeback slot
// Ports: clk, reset (sync, active-high); unit_done/unit_rd/unit_fp/clear_rd per unit;
//        mem_stall, debug_on; unit_ack (comb pop); wb_valid/wb_rd/wb_fp/wb_unit
//        (registered slot); contention (more than one eligible requester).
module uu_wb_arbiter
   import uu_wb_arbiter_pkg::*;
#(
   parameter int NUM_UNITS = NUM_UNITS_DEF,
   parameter int RD_W      = RD_W_DEF,
   parameter int ID_W      = ID_W_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_UNITS-1:0]      unit_done,
   input  logic [RD_W*NUM_UNITS-1:0] unit_rd,
   input  logic [NUM_UNITS-1:0]      unit_fp,
   input  logic [NUM_UNITS-1:0]      clear_rd,
   input  logic                      mem_stall,
   input  logic                      debug_on,
   output logic [NUM_UNITS-1:0]      unit_ack,
   output logic                      wb_valid,
   output logic [RD_W-1:0]           wb_rd,
   output logic                      wb_fp,
   output logic [ID_W-1:0]           wb_unit,
   output logic                      contention
);

   logic            wb_valid_q, wb_valid_d;
   wb_slot_t        slot_q, slot_d;
   logic [ID_W-1:0] ptr_q, ptr_d;

   logic [NUM_UNITS-1:0] eligible;
   logic [NUM_UNITS-1:0] discard;
   logic [NUM_UNITS-1:0] pick_gnt;
   logic [NUM_UNITS-1:0] grant;
   logic [ID_W-1:0]      pick_idx;
   logic                 pick_valid;
   logic                 can_load;
   logic [RD_W-1:0]      rd_sel;
   logic                 fp_sel;

   // A clear on a done unit wins over a grant: it is discarded, never eligible.
   assign eligible = unit_done & ~clear_rd & {NUM_UNITS{~debug_on}};
   assign discard  = unit_done &  clear_rd & {NUM_UNITS{~debug_on}};
   assign can_load = ~mem_stall | ~wb_valid_q;
   assign grant    = can_load ? pick_gnt : '0;

   // Acks are suppressed during reset so nothing is popped while state clears.
   assign unit_ack   = reset ? '0 : (grant | discard);
   assign contention = ($countones(eligible) > 1);

   rr_priority_picker #(
      .N  (NUM_UNITS),
      .IW (ID_W)
   ) u_picker (
      .req       (eligible),
      .ptr       (ptr_q),
      .gnt       (pick_gnt),
      .gnt_idx   (pick_idx),
      .gnt_valid (pick_valid)
   );

   // Payload mux driven by the one-hot grant.
   always_comb begin
      rd_sel = '0;
      fp_sel = 1'b0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (pick_gnt[i]) begin
            rd_sel = unit_rd[i*RD_W +: RD_W];
            fp_sel = unit_fp[i];
         end
      end
   end

   always_comb begin
      wb_valid_d = wb_valid_q;
      slot_d     = slot_q;
      ptr_d      = ptr_q;
      if (can_load) begin
         // Nothing eligible drains the slot; payload is left as it was.
         wb_valid_d = pick_valid;
         if (pick_valid) begin
            slot_d.rd   = RD_W_DEF'(rd_sel);
            slot_d.fp   = fp_sel;
            slot_d.unit = ID_W_DEF'(pick_idx);
            if (pick_idx == ID_W'(NUM_UNITS - 1)) begin
               ptr_d = '0;
            end else begin
               ptr_d = pick_idx + ID_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_valid_q <= 1'b0;
         slot_q     <= '0;
         ptr_q      <= '0;
      end else begin
         wb_valid_q <= wb_valid_d;
         slot_q     <= slot_d;
         ptr_q      <= ptr_d;
      end
   end

   assign wb_valid = wb_valid_q;
   assign wb_rd    = slot_q.rd[RD_W-1:0];
   assign wb_fp    = slot_q.fp;
   assign wb_unit  = slot_q.unit[ID_W-1:0];

endmodule

// File: tb/tb_uu_wb_arbiter.sv
// tb/tb_uu_wb_arbiter.sv - directed self-checking bench for uu_wb_arbiter
module tb_uu_wb_arbiter;

   localparam int N    = 9;
   localparam int RD_W = 5;
   localparam int ID_W = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      unit_done;
   logic [RD_W*N-1:0] unit_rd;
   logic [N-1:0]      unit_fp;
   logic [N-1:0]      clear_rd;
   logic              mem_stall;
   logic              debug_on;
   logic [N-1:0]      unit_ack;
   logic              wb_valid;
   logic [RD_W-1:0]   wb_rd;
   logic              wb_fp;
   logic [ID_W-1:0]   wb_unit;
   logic              contention;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   uu_wb_arbiter #(.NUM_UNITS(N), .RD_W(RD_W), .ID_W(ID_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .unit_done  (unit_done),
      .unit_rd    (unit_rd),
      .unit_fp    (unit_fp),
      .clear_rd   (clear_rd),
      .mem_stall  (mem_stall),
      .debug_on   (debug_on),
      .unit_ack   (unit_ack),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .wb_fp      (wb_fp),
      .wb_unit    (wb_unit),
      .contention (contention)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle; registered outputs are then stable.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_slot(input string tag, input int unit);
      chk({tag, "_valid"}, 32'(wb_valid), 32'd1);
      chk({tag, "_unit"},  32'(wb_unit),  32'(unit));
      chk({tag, "_rd"},    32'(wb_rd),    32'(unit + 4));
      chk({tag, "_fp"},    32'(wb_fp),    32'(unit % 2));
   endtask

   initial begin
      reset     = 1'b1;
      unit_done = '0;
      clear_rd  = '0;
      mem_stall = 1'b0;
      debug_on  = 1'b0;
      // Unit i writes rd=i+4, FP file for odd units.
      for (int i = 0; i < N; i++) begin
         unit_rd[i*RD_W +: RD_W] = RD_W'(i + 4);
         unit_fp[i]              = i[0];
      end

      // Reset state
      tick();
      tick();
      chk("rst_valid", 32'(wb_valid), 0);
      chk("rst_rd",    32'(wb_rd),    0);
      chk("rst_fp",    32'(wb_fp),    0);
      chk("rst_unit",  32'(wb_unit),  0);
      chk("rst_ack",   32'(unit_ack), 0);
      reset = 1'b0;

      // Single unit 3: ack same cycle, slot next cycle
      unit_done = 9'h008;
      #1;
      chk("single_ack",  32'(unit_ack),   32'h008);
      chk("single_cont", 32'(contention), 0);
      tick();
      unit_done = '0;
      chk_slot("single", 3);

      // ptr now 4: units 3 and 4 -> 4 first, then 3
      unit_done = 9'h018;
      #1;
      chk("ptr4_ack",  32'(unit_ack),   32'h010);
      chk("ptr4_cont", 32'(contention), 1);
      tick();
      chk_slot("ptr4", 4);
      unit_done = 9'h008;
      #1;
      chk("ptr5_ack", 32'(unit_ack), 32'h008);
      tick();
      chk_slot("ptr5", 3);
      unit_done = '0;
      #1;
      chk("drain0_ack", 32'(unit_ack), 0);
      tick();
      chk("drain0_valid", 32'(wb_valid), 0);

      // Move ptr to 0 by granting unit 8
      unit_done = 9'h100;
      #1;
      chk("to0_ack", 32'(unit_ack), 32'h100);
      tick();
      unit_done = '0;
      tick();
      chk("to0_drain", 32'(wb_valid), 0);

      // Contention 1,4,8 from ptr 0
      unit_done = 9'h112;
      #1;
      chk("cont1_ack",  32'(unit_ack),   32'h002);
      chk("cont1_cont", 32'(contention), 1);
      tick();
      chk_slot("cont1", 1);
      unit_done = 9'h110;
      #1;
      chk("cont2_ack",  32'(unit_ack),   32'h010);
      chk("cont2_cont", 32'(contention), 1);
      tick();
      chk_slot("cont2", 4);
      unit_done = 9'h100;
      #1;
      chk("cont3_ack",  32'(unit_ack),   32'h100);
      chk("cont3_cont", 32'(contention), 0);
      tick();
      chk_slot("cont3", 8);
      unit_done = '0;
      tick();
      chk("cont_drain", 32'(wb_valid), 0);

      // Stall: load unit 0 (ptr 0 -> 1), then stall 3 cycles with unit 2 done
      unit_done = 9'h001;
      tick();
      chk_slot("stall_load", 0);
      unit_done = 9'h004;
      mem_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k == 1) begin
            unit_done = 9'h084;
            clear_rd  = 9'h080;
         end else begin
            unit_done = 9'h004;
            clear_rd  = '0;
         end
         #1;
         chk("stall_ack", 32'(unit_ack), (k == 1) ? 32'h080 : 32'h000);
         tick();
         chk_slot("stall_hold", 0);
      end
      mem_stall = 1'b0;
      clear_rd  = '0;
      unit_done = 9'h004;
      #1;
      chk("unstall_ack", 32'(unit_ack), 32'h004);
      tick();
      chk_slot("unstall", 2);

      // Discard 5 alongside grant 6 (ptr 3)
      unit_done = 9'h060;
      clear_rd  = 9'h020;
      #1;
      chk("disc_ack",  32'(unit_ack),   32'h060);
      chk("disc_cont", 32'(contention), 0);
      tick();
      chk_slot("disc", 6);
      unit_done = '0;
      clear_rd  = '0;
      tick();
      chk("disc_drain", 32'(wb_valid), 0);

      // Wrap: ptr 7 -> grant 7 -> ptr 8; then units 0 and 8
      unit_done = 9'h080;
      tick();
      chk_slot("wrap_pre", 7);
      unit_done = 9'h101;
      #1;
      chk("wrap1_ack", 32'(unit_ack), 32'h100);
      tick();
      chk_slot("wrap1", 8);
      unit_done = 9'h001;
      #1;
      chk("wrap2_ack", 32'(unit_ack), 32'h001);
      tick();
      chk_slot("wrap2", 0);
      // ptr 1: units 0 and 1 -> 1 wins
      unit_done = 9'h003;
      #1;
      chk("wrap_ptr1_ack", 32'(unit_ack), 32'h002);
      tick();
      chk_slot("wrap_ptr1", 1);

      // Reset mid-op with slot full and units 2,5,7 done
      unit_done = 9'h0a4;
      reset     = 1'b1;
      #1;
      chk("midrst_ack0", 32'(unit_ack), 0);
      tick();
      chk("midrst_valid", 32'(wb_valid), 0);
      chk("midrst_rd",    32'(wb_rd),    0);
      chk("midrst_fp",    32'(wb_fp),    0);
      chk("midrst_unit",  32'(wb_unit),  0);
      chk("midrst_ack1",  32'(unit_ack), 0);
      reset = 1'b0;
      #1;
      chk("postrst_ack",  32'(unit_ack),   32'h004);
      chk("postrst_cont", 32'(contention), 1);
      tick();
      chk_slot("postrst", 2);

      // Debug freeze: no grants, no discards; slot drains
      unit_done = 9'h030;
      clear_rd  = 9'h010;
      debug_on  = 1'b1;
      #1;
      chk("dbg_ack",  32'(unit_ack),   0);
      chk("dbg_cont", 32'(contention), 0);
      tick();
      chk("dbg_valid", 32'(wb_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/uu_wb_arbiter.md
UU_WB_ARBITER -- requirements
Module: uu_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 9, number of execution units sharing the writeback slot.
REQ-002 SHALL have parameter RD_W, default 5, rd address width.
REQ-003 SHALL have parameter ID_W, default 4, unit-index width, at least clog2(NUM_UNITS).
REQ-004 SHALL have port clk, input, 1: the single clock. All state changes on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port unit_done, input, NUM_UNITS: unit i holds a finished result and keeps it asserted until acked.
REQ-007 SHALL have port unit_rd, input, RD_W x NUM_UNITS: destination register of each unit.
REQ-008 SHALL have port unit_fp, input, NUM_UNITS: 1 means the rd is in the FP file, 0 means the integer file.
REQ-009 SHALL have port clear_rd, input, NUM_UNITS: WAW kill from the clear decoder. The unit's result is discarded.
REQ-010 SHALL have port mem_stall, input, 1: the MEM stage cannot accept a writeback this cycle.
REQ-011 SHALL have port debug_on, input, 1: freeze; no new grants and no discards.
REQ-012 SHALL have port unit_ack, output, NUM_UNITS: combinational pop to unit i (grant or discard).
REQ-013 SHALL have port wb_valid, output, 1: the registered writeback slot holds a result.
REQ-014 SHALL have ports wb_rd (RD_W), wb_fp (1) and wb_unit (ID_W), output, 1 each: payload of the registered slot.
REQ-015 SHALL have port contention, output, 1: more than one eligible requester this cycle. Feeds the hazard unit.

Function
REQ-016 Eligibility: eligible[i] = unit_done[i] and not clear_rd[i] and not debug_on.
REQ-017 Discard: unit_done[i] and clear_rd[i] and not debug_on asserts unit_ack[i] the same cycle. The discarded result never reaches wb_*.
REQ-018 Slot advance: the slot may load when not mem_stall, or when wb_valid=0.
- If the slot may load and any unit is eligible, exactly one unit is granted.
- The granted unit gets unit_ack the same cycle.
- Next cycle: wb_valid=1 and wb_rd/wb_fp/wb_unit equal the granted unit's values.
REQ-019 Grant latency: done at cycle n with no competition and no stall gives wb_valid at n+1.
REQ-020 Round-robin: the search starts at pointer ptr and wraps modulo NUM_UNITS. After a grant to unit g, ptr = (g+1) mod NUM_UNITS. ptr does not change without a grant.
REQ-021 Fairness: a continuously eligible unit is granted within NUM_UNITS slot-advance cycles.
REQ-022 Stall: mem_stall=1 with wb_valid=1 holds all wb_* outputs, issues no grant ack, and leaves ptr unchanged. Discards still occur.
REQ-023 Drain: when the slot may load and nothing is eligible, wb_valid becomes 0 next cycle.
REQ-024 Simultaneous clear and grant candidate on the same unit: clear wins (discard, no grant).
REQ-025 Index range: when NUM_UNITS is not a power of two, ptr never takes a value of NUM_UNITS or above.
REQ-026 contention = popcount(eligible) > 1, computed combinationally.
REQ-027 The arbiter SHALL NOT compare rd values; all hazard decisions arrive via clear_rd.

Reset
REQ-028 On reset=1 at a clock edge:
- wb_valid=0, wb_rd=0, wb_fp=0, wb_unit=0, ptr=0.
REQ-029 While reset=1, unit_ack SHALL be all zero, so no result is popped mid-reset. Pending unit_done is re-arbitrated after release.

Structure
REQ-030 The shared package SHALL hold:
- the NUM_UNITS default and the unit-index typedef;
- a wb_slot_t struct (rd, fp, unit).
REQ-031 Round-robin selection SHALL be a sub-module rr_priority_picker (request vector, ptr) -> one-hot grant plus index.
REQ-032 All state is in a single always_ff. Output payload comes directly from registers.

Verification
REQ-033 Single unit: unit_done[3]=1, rd=7, fp=1, no stall. Expect unit_ack[3] in cycle n, then wb_valid=1, wb_rd=7, wb_fp=1, wb_unit=3 at n+1, and ptr=4.
REQ-034 Contention: ptr=0 and units 1, 4, 8 all done and held. Expect grants 1, 4, 8 in consecutive cycles, contention=1 for the first two cycles, and wb_valid low after the third drains.
REQ-035 Stall: wb_valid=1 and mem_stall=1 for 3 cycles while unit 2 is done. Expect wb_* stable, no unit_ack[2]; then unit 2 granted in the first non-stall cycle.
REQ-036 Discard: unit_done[5]=1 and clear_rd[5]=1 in the same cycle as unit 6 done. Expect unit_ack[5] and unit_ack[6] both high, and only rd of unit 6 appearing in wb_*.
REQ-037 Reset mid-op: reset asserted while wb_valid=1 and three units done. Expect all outputs 0 the next cycle, no acks during reset, and arbitration from ptr=0 after release (unit with lowest index granted first).
REQ-038 Wrap: ptr=8 with units 0 and 8 done. Expect unit 8 granted first, then unit 0, and ptr=1.
